// File: rtl/dct_row_sequencer.sv
// dct_row_sequencer: feeds pixel rows through the combinational row-DCT stage,
// captures each coefficient row into an NxN transpose buffer, then streams the
// buffer back out column by column for the column DCT pass.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_LOAD  | accepting rows; each accepted row's DCT result lands in buf_q
// S_DRAIN | presenting buffered columns; input stream is stalled
module dct_row_sequencer #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 9,
  parameter int N      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*PIX_W-1:0]    in_row,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N*PIX_W-1:0]    dct_in,
  input  logic [N*COEF_W-1:0]   dct_out,
  output logic [N*COEF_W-1:0]   out_col,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int OUT_W = N * COEF_W;
  localparam int CW    = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic {
    S_LOAD,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      row_cnt_q, row_cnt_d;
  logic [CW-1:0]      col_cnt_q, col_cnt_d;
  logic [OUT_W-1:0]   buf_q [N];

  logic               in_accept;
  logic               out_accept;

  // The DCT stage is combinational, so its input is a straight wire.
  assign dct_in = in_row;

  // Reset forces the idle handshake view regardless of the registered state.
  assign in_accept  = !rst && (state_q == S_LOAD)  && in_valid;
  assign out_accept = !rst && (state_q == S_DRAIN) && out_ready;

  assign in_ready  = rst || (state_q == S_LOAD);
  assign out_valid = !rst && (state_q == S_DRAIN);
  assign out_last  = out_valid && (col_cnt_q == LAST_IDX);
  assign busy      = !rst && ((state_q == S_DRAIN) || (row_cnt_q != '0));

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  // Transpose buffer: capture the DCT result of the row accepted this cycle.
  // Contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (in_accept) begin
      buf_q[row_cnt_q] <= dct_out;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_accept) begin
          if (row_cnt_q == LAST_IDX) begin
            row_cnt_d = '0;
            state_d   = S_DRAIN;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (out_accept) begin
          if (col_cnt_q == LAST_IDX) begin
            col_cnt_d = '0;
            state_d   = S_LOAD;
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Column mux: field col_cnt of every buffered row, row 0 in the MSBs.
  always_comb begin
    out_col = '0;
    for (int i = 0; i < N; i++) begin
      out_col[OUT_W-1-COEF_W*i -: COEF_W] =
        buf_q[i][OUT_W-1-COEF_W*int'(col_cnt_q) -: COEF_W];
    end
  end

endmodule

// File: tb/tb_dct_row_sequencer.sv
// Bench for dct_row_sequencer. A stand-in row-DCT stage is driven from dct_in;
// a queue-level model predicts the handshake and column data every cycle.
module tb_dct_row_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_row;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dct_in;
  logic [71:0] dct_out;
  logic [71:0] out_col;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  dct_row_sequencer #(.PIX_W(8), .COEF_W(9), .N(8)) dut (
    .clk(clk), .rst(rst), .in_row(in_row), .in_valid(in_valid),
    .in_ready(in_ready), .dct_in(dct_in), .dct_out(dct_out),
    .out_col(out_col), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  // Stand-in DCT stage: DC = sum*90/1024, coef4 = alternating sum*90/1024,
  // other coefficients = p0 ^ pk (zero for a flat row).
  function automatic logic [71:0] fake_dct(input logic [63:0] r);
    int p [8];
    int s, a;
    logic [71:0] o;
    logic [8:0] c;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      p[i] = int'(r[63-8*i -: 8]);
      s += p[i];
    end
    a = p[0] - p[1] - p[2] + p[3] + p[4] - p[5] - p[6] + p[7];
    o = '0;
    c = 9'((s * 90) >>> 10);
    o[71 -: 9] = c;
    c = 9'((a * 90) >>> 10);
    o[35 -: 9] = c;
    for (int k = 1; k < 8; k++) begin
      if (k != 4) begin
        c = 9'(p[0] ^ p[k]);
        o[71-9*k -: 9] = c;
      end
    end
    return o;
  endfunction

  always_comb dct_out = fake_dct(dct_in);

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: rows collect until 8 are held, then become 8 pending columns.
  logic [63:0] m_rows [$];
  logic [71:0] m_cols [$];
  logic [71:0] m_col, m_cf;

  always @(posedge clk) begin
    if (rst) begin
      m_rows.delete();
      m_cols.delete();
    end else if (m_cols.size() != 0) begin
      if (out_ready) void'(m_cols.pop_front());
    end else if (in_valid) begin
      m_rows.push_back(in_row);
      if (m_rows.size() == 8) begin
        for (int j = 0; j < 8; j++) begin
          m_col = '0;
          for (int i = 0; i < 8; i++) begin
            m_cf = fake_dct(m_rows[i]);
            m_col[71-9*i -: 9] = m_cf[71-9*j -: 9];
          end
          m_cols.push_back(m_col);
        end
        m_rows.delete();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_rdy, e_vld, e_last, e_busy;
      e_rdy  = rst || (m_cols.size() == 0);
      e_vld  = !rst && (m_cols.size() != 0);
      e_last = e_vld && (m_cols.size() == 1);
      e_busy = !rst && ((m_rows.size() != 0) || (m_cols.size() != 0));
      chk("in_ready", 72'(in_ready), 72'(e_rdy));
      chk("out_valid", 72'(out_valid), 72'(e_vld));
      chk("out_last", 72'(out_last), 72'(e_last));
      chk("busy", 72'(busy), 72'(e_busy));
      chk("dct_in", 72'(dct_in), 72'(in_row));
      if (e_vld) chk("out_col", out_col, m_cols[0]);
    end
  end

  logic [71:0] got_col [8];
  logic        got_last [8];
  int          last_in_cyc, last_acc_cyc;

  task automatic put_row(input logic [63:0] r);
    bit rdy;
    int guard;
    rdy = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_row = r;
    while (!rdy && guard < 300) begin
      guard++;
      @(negedge clk);
      rdy = in_ready && !rst;
      @(posedge clk);
      #1;
    end
    last_in_cyc = cyc;
    if (!rdy) chk("row_accept_timeout", 72'(rdy), 72'(1));
  endtask

  task automatic drain(input int n, input int stall_at, input int stall_len, input bit keep_in);
    int acc, st, guard;
    bit take;
    acc = 0; st = 0; guard = 0;
    while (acc < n && guard < 300) begin
      guard++;
      if (acc == stall_at && st < stall_len) begin
        out_ready = 1'b0;
        st++;
        if (!keep_in) begin
          in_valid = st[0];
          in_row = {$urandom, $urandom};
        end
      end else begin
        out_ready = 1'b1;
        if (!keep_in) in_valid = 1'b0;
      end
      @(negedge clk);
      take = out_valid && out_ready;
      if (take) begin
        got_col[acc] = out_col;
        got_last[acc] = out_last;
      end
      @(posedge clk);
      #1;
      if (take) begin
        last_acc_cyc = cyc;
        acc++;
      end
    end
    out_ready = 1'b0;
    if (!keep_in) in_valid = 1'b0;
    if (acc < n) chk("drain_timeout", 72'(acc), 72'(n));
  endtask

  task automatic send_block(input logic [63:0] b [8]);
    for (int i = 0; i < 8; i++) put_row(b[i]);
    in_valid = 1'b0;
  endtask

  logic [63:0] flat [8];
  logic [63:0] imp [8];
  logic [63:0] rnd [8];
  logic [63:0] rnd2 [8];
  logic [71:0] col_dc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      flat[i] = 64'h8080808080808080;
      imp[i]  = (i == 0) ? 64'hFF00000000000000 : 64'h0;
      rnd[i]  = {$urandom, $urandom};
      rnd2[i] = {$urandom, $urandom};
    end
    col_dc = {8{9'h05A}};

    // Reset: two cycles asserted, then released.
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 72'(in_ready), 72'(1));
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_out_last", 72'(out_last), 72'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 72'(in_ready), 72'(1));
    chk("post_rst_out_valid", 72'(out_valid), 72'(0));
    chk("post_rst_busy", 72'(busy), 72'(0));
    @(posedge clk); #1;

    // Flat block.
    send_block(flat);
    drain(8, -1, 0, 1'b0);
    chk("flat_col0", got_col[0], col_dc);
    for (int j = 1; j < 8; j++) chk("flat_colN_zero", got_col[j], 72'h0);
    for (int j = 0; j < 8; j++) chk("flat_last", 72'(got_last[j]), 72'(j == 7));

    // Impulse row.
    send_block(imp);
    drain(8, -1, 0, 1'b0);
    chk("imp_c0_r0", 72'(got_col[0][71:63]), 72'd22);
    chk("imp_c4_r0", 72'(got_col[4][71:63]), 72'd22);
    for (int j = 0; j < 8; j++) chk("imp_rows1_7_zero", 72'(got_col[j][62:0]), 72'h0);

    // Backpressure at column 3 with in_valid pulsing.
    send_block(rnd);
    drain(8, 3, 5, 1'b0);

    // Back-to-back: block 2 row 0 offered while block 1 drains.
    for (int i = 0; i < 8; i++) put_row(rnd[i]);
    in_row = rnd2[0];
    drain(8, -1, 0, 1'b1);
    put_row(rnd2[0]);
    chk("b2b_row0_delay", 72'(last_in_cyc - last_acc_cyc), 72'd1);
    begin
      int b0;
      b0 = last_in_cyc;
      for (int i = 1; i < 8; i++) put_row(rnd2[i]);
      drain(8, -1, 0, 1'b0);
      chk("b2b_block_cycles", 72'(last_acc_cyc - b0 + 1), 72'd16);
    end

    // Mid-load reset after 5 rows.
    for (int i = 0; i < 5; i++) put_row(rnd2[i]);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midload_rst_busy", 72'(busy), 72'(0));
    @(posedge clk); #1;
    send_block(flat);
    drain(8, -1, 0, 1'b0);
    chk("after_rst_flat_col0", got_col[0], col_dc);

    // Mid-drain reset at column 4.
    send_block(imp);
    drain(4, -1, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("middrain_rst_busy", 72'(busy), 72'(0));
    chk("middrain_rst_valid", 72'(out_valid), 72'(0));
    @(posedge clk); #1;
    send_block(flat);
    drain(8, -1, 0, 1'b0);
    chk("after_rst2_flat_col0", got_col[0], col_dc);
    chk("after_rst2_flat_col4", got_col[4], 72'h0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
